// File: rtl/sub64_seq.sv
// ============================================================================
// Module   : sub64_seq
// Function : Sequential 64-bit signed subtractor, one 16-bit slice per cycle.
//            Optional zf/sf/of flags when the SUB64_FLAGS_EN macro is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sub64_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [63:0] p,
  input  logic signed [63:0] q,
  output logic signed [63:0] r,
  output logic               carry,
  output logic               busy,
  output logic               done,
  output logic               zf,
  output logic               sf,
  output logic               of
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] p_q;
  logic [63:0] q_q;
  logic [63:0] acc_q;
  logic [1:0]  cnt_q;
  logic        cin_q;

  logic [15:0] p_slice_d;
  logic [15:0] q_slice_d;
  logic [16:0] slice_sum_d;
  logic [63:0] res_d;
  logic        last_d;

  // Each new slice enters at the top of acc_q; after four shifts slice 0 sits in bits 15:0.
  always_comb begin
    p_slice_d   = p_q[{cnt_q, 4'b0000} +: 16];
    q_slice_d   = q_q[{cnt_q, 4'b0000} +: 16];
    slice_sum_d = {1'b0, p_slice_d} + {1'b0, ~q_slice_d} + {16'd0, cin_q};
    res_d       = {slice_sum_d[15:0], acc_q[63:16]};
    last_d      = (state_q == RUN) && (cnt_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 64'd0;
      q_q     <= 64'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 2'd0;
      cin_q   <= 1'b0;
      r       <= 64'sd0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            p_q     <= p;
            q_q     <= q;
            acc_q   <= 64'd0;
            cnt_q   <= 2'd0;
            cin_q   <= 1'b1;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= res_d;
          cin_q <= slice_sum_d[16];
          cnt_q <= cnt_q + 2'd1;
          if (last_d) begin
            r       <= res_d;
            carry   <= slice_sum_d[16];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SUB64_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (last_d) begin
      zf <= (res_d == 64'd0);
      sf <= res_d[63];
      of <= (p_q[63] != q_q[63]) && (res_d[63] != p_q[63]);
    end
  end
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub64_seq.sv
// ============================================================================
// Module   : tb_sub64_seq
// Function : Directed self-checking bench for sub64_seq (flags follow SUB64_FLAGS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sub64_seq;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [63:0] p;
  logic signed [63:0] q;
  logic signed [63:0] r;
  logic               carry;
  logic               busy;
  logic               done;
  logic               zf;
  logic               sf;
  logic               of;

  int vectors;
  int miscompares;

`ifdef SUB64_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  sub64_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .q     (q),
    .r     (r),
    .carry (carry),
    .busy  (busy),
    .done  (done),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation and waits (bounded) for done; lat counts edges after acceptance.
  task automatic do_op(input logic [63:0] pa, input logic [63:0] qa,
                       output int lat, output bit timed_out);
    start = 1'b1;
    p     = pa;
    q     = qa;
    @(posedge clk); #1;
    start     = 1'b0;
    lat       = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    p     = 64'd9;
    q     = 64'd1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({r, carry, busy, done, zf, sf, of} !== {64'd0, 6'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got r=%h c=%b b=%b d=%b z=%b s=%b o=%b, want all 0",
               r, carry, busy, done, zf, sf, of);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_arith;
    logic [63:0] tp [7];
    logic [63:0] tq [7];
    logic [63:0] tr [7];
    logic [3:0]  tf [7]; // {carry, zf, sf, of}
    int lat;
    bit to;
    tp[0] = 64'd5;                   tq[0] = 64'd3;
    tr[0] = 64'd2;                   tf[0] = 4'b1000;
    tp[1] = 64'd3;                   tq[1] = 64'd5;
    tr[1] = 64'hFFFF_FFFF_FFFF_FFFE; tf[1] = 4'b0010;
    tp[2] = 64'h8000_0000_0000_0000; tq[2] = 64'd1;
    tr[2] = 64'h7FFF_FFFF_FFFF_FFFF; tf[2] = 4'b1001;
    tp[3] = 64'd2147483648;          tq[3] = 64'd2147483648;
    tr[3] = 64'd0;                   tf[3] = 4'b1100;
    tp[4] = -64'sd95;                tq[4] = 64'd23;
    tr[4] = 64'hFFFF_FFFF_FFFF_FF8A; tf[4] = 4'b1010;
    tp[5] = 64'h0001_0000_0000_0000; tq[5] = 64'd1;
    tr[5] = 64'h0000_FFFF_FFFF_FFFF; tf[5] = 4'b1000;
    tp[6] = 64'd0;                   tq[6] = 64'h8000_0000_0000_0000;
    tr[6] = 64'h8000_0000_0000_0000; tf[6] = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      do_op(tp[i], tq[i], lat, to);
      vectors++;
      if (to || lat != 4) begin
        miscompares++;
        $display("FAIL arith_latency[%0d]: got lat=%0d timeout=%0b, want 4", i, lat, to);
      end
      vectors++;
      if (r !== tr[i]) begin
        miscompares++;
        $display("FAIL arith_r[%0d]: got %h, want %h", i, r, tr[i]);
      end
      vectors++;
      if (carry !== tf[i][3]) begin
        miscompares++;
        $display("FAIL arith_carry[%0d]: got %b, want %b", i, carry, tf[i][3]);
      end
      vectors++;
      if ({zf, sf, of} !== (FLAGS ? tf[i][2:0] : 3'b000)) begin
        miscompares++;
        $display("FAIL arith_flags[%0d]: got zso=%b%b%b, want %b", i, zf, sf, of,
                 FLAGS ? tf[i][2:0] : 3'b000);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL arith_busy_done[%0d]: got busy=%b, want 0", i, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || r !== tr[i]) begin
        miscompares++;
        $display("FAIL arith_hold[%0d]: got done=%b r=%h, want 0 %h", i, done, r, tr[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone;
    logic [63:0] got_r;
    bit busy_ok;
    start = 1'b1;
    p     = 64'd44;
    q     = 64'd4;
    @(posedge clk); #1;
    p = 64'd14;
    q = 64'd9;
    @(posedge clk); #1;
    start   = 1'b0;
    busy_ok = (busy === 1'b1);
    ndone   = 0;
    got_r   = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        got_r = r;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (!busy_ok) begin
      miscompares++;
      $display("FAIL ignore_busy: busy not 1 in RUN, want 1");
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d done pulses, want 1", ndone);
    end
    vectors++;
    if (got_r !== 64'd40) begin
      miscompares++;
      $display("FAIL ignore_r: got %0d, want 40", got_r);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit to;
    do_op(64'd20, 64'd7, lat, to);
    vectors++;
    if (to || r !== 64'd13) begin
      miscompares++;
      $display("FAIL b2b_first: got r=%0d timeout=%0b, want 13", r, to);
    end
    start = 1'b1;
    p     = 64'd14;
    q     = 64'd9;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || r !== 64'd13) begin
      miscompares++;
      $display("FAIL b2b_accept: got done=%b busy=%b r=%0d, want 0 1 13", done, busy, r);
    end
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    vectors++;
    if (to || lat != 4 || r !== 64'd5) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d timeout=%0b r=%0d, want 4 0 5", lat, to, r);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int ndone;
    bit to;
    do_op(64'd5, 64'd3, lat, to);
    @(posedge clk); #1;
    start = 1'b1;
    p     = 64'd100;
    q     = 64'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || r !== 64'd0 || carry !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b done=%b r=%0d carry=%b, want 0 0 0 0",
               busy, done, r, carry);
    end
    vectors++;
    if ({zf, sf, of} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_flags: got zso=%b%b%b, want 000", zf, sf, of);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    vectors++;
    if (ndone != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", ndone);
    end
    do_op(64'd7, 64'd10, lat, to);
    vectors++;
    if (to || lat != 4 || r !== 64'hFFFF_FFFF_FFFF_FFFD || carry !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_recover: got lat=%0d r=%h carry=%b, want 4 fffffffffffffffd 0",
               lat, r, carry);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    p           = '0;
    q           = '0;
    test_reset();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
